umstr_axil_reg_if_rd_mstr: RTL and testbench

Register-interface-to-AXI-Lite read master: accepts single-word read requests on the UDP master's internal register interface and issues them as AXI-Lite read transactions. It returns the read data and a one-cycle ack to the requester. It is the initiating end of the AXI-Lite read channel that the block's register-interface slave bridges terminate. It holds `reg_rd_wait` high while a transaction is in flight, so upstream slave-side timeouts are suspended. It enforces its own response timeout, with a bus-error return value, and drains orphaned responses.

---
 rtl/umstr_axil_reg_if_rd_mstr.sv | 176 +++++++++++++++++
 tb/tb_umstr_axil_reg_if_rd_mstr.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umstr_axil_reg_if_rd_mstr.sv
// Register-interface to AXI-Lite read master.
// Turns single-word register reads into AXI-Lite AR/R transactions. The
// requester is held off with reg_rd_wait while a read is in flight. A response
// timeout returns TIMEOUT_DATA with an error, and the abandoned AXI transaction
// is then drained so the channel stays compliant.
module umstr_axil_reg_if_rd_mstr #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [2:0]            ARPROT       = 3'b000,
  parameter int                    TIMEOUT      = 64,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] reg_rd_addr,
  input  logic                  reg_rd_en,
  output logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  reg_rd_wait,
  output logic                  reg_rd_ack,
  output logic                  reg_rd_err,
  output logic                  timeout_evt,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  localparam int             CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT);
  localparam bit             TO_EN    = (TIMEOUT > 0);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    RESP,
    DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  wait_q, wait_d;
  logic                  tmo_q, tmo_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  expire;

  // The budget runs out on the stall cycle that sees a count of one.
  assign expire = TO_EN && (cnt_q == CNT_W'(1));

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    data_d    = data_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    tmo_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (reg_rd_en) begin
          araddr_d  = reg_rd_addr;
          arvalid_d = 1'b1;
          cnt_d     = CNT_LOAD;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        // A handshake in the expiry cycle wins over the timeout.
        if (m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end else if (expire) begin
          data_d  = TIMEOUT_DATA;
          err_d   = 1'b1;
          ack_d   = 1'b1;
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = DRAIN;
        end else if (TO_EN) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (m_axil_rvalid) begin
          data_d   = m_axil_rdata;
          err_d    = (m_axil_rresp != 2'b00);
          rready_d = 1'b0;
          ack_d    = 1'b1;
          state_d  = RESP;
        end else if (expire) begin
          data_d  = TIMEOUT_DATA;
          err_d   = 1'b1;
          ack_d   = 1'b1;
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = DRAIN;
        end else if (TO_EN) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        // Gap cycle: the requester's still-high reg_rd_en is ignored here.
        state_d = IDLE;
      end
      DRAIN: begin
        // Finish the abandoned transaction and discard its R beat.
        if (arvalid_q) begin
          if (m_axil_arready) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
          end
        end else if (m_axil_rvalid) begin
          rready_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wait_d = (state_d == ADDR) || (state_d == DATA);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q   <= IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      data_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      wait_q    <= 1'b0;
      tmo_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      data_q    <= data_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      wait_q    <= wait_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign reg_rd_data    = data_q;
  assign reg_rd_wait    = wait_q;
  assign reg_rd_ack     = ack_q;
  assign reg_rd_err     = err_q;
  assign timeout_evt    = tmo_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = ARPROT;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_umstr_axil_reg_if_rd_mstr.sv
// Bench for umstr_axil_reg_if_rd_mstr.
// Each request is described by its address, AR/R stall counts, response and
// gap; a schedule computes from those when every output should be active, and
// the run loop drives requester and slave from the same schedule while
// comparing every output every cycle.
module tb_umstr_axil_reg_if_rd_mstr;

  localparam int TO = 8;
  localparam logic [31:0] TO_DATA = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] reg_rd_addr;
  logic        reg_rd_en;
  logic [31:0] reg_rd_data;
  logic        reg_rd_wait;
  logic        reg_rd_ack;
  logic        reg_rd_err;
  logic        timeout_evt;
  logic [31:0] m_axil_araddr;
  logic [2:0]  m_axil_arprot;
  logic        m_axil_arvalid;
  logic        m_axil_arready;
  logic [31:0] m_axil_rdata;
  logic [1:0]  m_axil_rresp;
  logic        m_axil_rvalid;
  logic        m_axil_rready;

  int total = 0;
  int bad   = 0;

  umstr_axil_reg_if_rd_mstr #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .ARPROT    (3'b000),
    .TIMEOUT   (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .reg_rd_addr   (reg_rd_addr),
    .reg_rd_en     (reg_rd_en),
    .reg_rd_data   (reg_rd_data),
    .reg_rd_wait   (reg_rd_wait),
    .reg_rd_ack    (reg_rd_ack),
    .reg_rd_err    (reg_rd_err),
    .timeout_evt   (timeout_evt),
    .m_axil_araddr (m_axil_araddr),
    .m_axil_arprot (m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid),
    .m_axil_arready(m_axil_arready),
    .m_axil_rdata  (m_axil_rdata),
    .m_axil_rresp  (m_axil_rresp),
    .m_axil_rvalid (m_axil_rvalid),
    .m_axil_rready (m_axil_rready)
  );

  always #5 clk = ~clk;

  // Request description plus its computed schedule (cycles relative to run start).
  typedef struct {
    logic [31:0] addr;
    int          ars;   // cycles arvalid is high before arready
    int          rs;    // cycles rready is high before rvalid
    logic [1:0]  resp;
    logic [31:0] data;
    int          gap;   // idle requester cycles after the previous ack
    int          r;     // requester raises reg_rd_en
    int          a;     // request accepted (IDLE sees reg_rd_en)
    int          ack;   // ack cycle
    bit          tmo;
    int          fin;   // last busy cycle
  } req_t;

  req_t plan_q[$];

  task automatic add_req(input logic [31:0] addr, input int ars, input int rs,
                         input logic [1:0] resp, input logic [31:0] data, input int gap);
    req_t q;
    q.addr = addr; q.ars = ars; q.rs = rs; q.resp = resp; q.data = data; q.gap = gap;
    q.r = 0; q.a = 0; q.ack = 0; q.tmo = 1'b0; q.fin = 0;
    plan_q.push_back(q);
  endtask

  // A read needs 3 cycles plus its stalls; a timeout fires once TO stall
  // cycles have passed (plus the cycle in which AR was accepted, if it was),
  // and the bus is busy until the abandoned R beat has been taken.
  task automatic schedule();
    int   free_at;
    req_t q;
    free_at = 0;
    for (int i = 0; i < plan_q.size(); i++) begin
      q     = plan_q[i];
      q.r   = (i == 0) ? 1 : plan_q[i-1].ack + 1 + q.gap;
      q.a   = (q.r > free_at) ? q.r : free_at;
      q.tmo = (q.ars + q.rs >= TO);
      if (q.tmo) begin
        q.ack   = (q.ars >= TO) ? q.a + 1 + TO : q.a + 2 + TO;
        q.fin   = q.a + 2 + q.ars + q.rs;
        free_at = q.fin + 1;
      end else begin
        q.ack   = q.a + 3 + q.ars + q.rs;
        q.fin   = q.ack;
        free_at = q.ack + 1;
      end
      plan_q[i] = q;
    end
  endtask

  task automatic run_plan(input string name);
    int          last;
    logic        e_ack, e_tmo, e_wait, e_arv, e_rr, e_err;
    logic [31:0] e_addr, e_data;
    schedule();
    last = plan_q[plan_q.size()-1].fin + 3;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      e_ack = 1'b0; e_tmo = 1'b0; e_wait = 1'b0; e_arv = 1'b0; e_rr = 1'b0; e_err = 1'b0;
      e_addr = '0; e_data = '0;
      foreach (plan_q[i]) begin
        if (c == plan_q[i].ack) begin
          e_ack  = 1'b1;
          e_tmo  = plan_q[i].tmo;
          e_data = plan_q[i].tmo ? TO_DATA : plan_q[i].data;
          e_err  = plan_q[i].tmo || (plan_q[i].resp != 2'b00);
        end
        if (c > plan_q[i].a && c < plan_q[i].ack) e_wait = 1'b1;
        if (c > plan_q[i].a && c <= plan_q[i].a + 1 + plan_q[i].ars) begin
          e_arv  = 1'b1;
          e_addr = plan_q[i].addr;
        end
        if (c >= plan_q[i].a + 2 + plan_q[i].ars && c <= plan_q[i].a + 2 + plan_q[i].ars + plan_q[i].rs)
          e_rr = 1'b1;
      end

      total++;
      if (reg_rd_ack !== e_ack) begin
        bad++; $display("FAIL %s c=%0d ack got=%b want=%b", name, c, reg_rd_ack, e_ack);
      end
      total++;
      if (timeout_evt !== e_tmo) begin
        bad++; $display("FAIL %s c=%0d timeout_evt got=%b want=%b", name, c, timeout_evt, e_tmo);
      end
      total++;
      if (reg_rd_wait !== e_wait) begin
        bad++; $display("FAIL %s c=%0d wait got=%b want=%b", name, c, reg_rd_wait, e_wait);
      end
      total++;
      if (m_axil_arvalid !== e_arv) begin
        bad++; $display("FAIL %s c=%0d arvalid got=%b want=%b", name, c, m_axil_arvalid, e_arv);
      end
      total++;
      if (m_axil_rready !== e_rr) begin
        bad++; $display("FAIL %s c=%0d rready got=%b want=%b", name, c, m_axil_rready, e_rr);
      end
      total++;
      if (m_axil_arprot !== 3'b000) begin
        bad++; $display("FAIL %s c=%0d arprot got=%b want=000", name, c, m_axil_arprot);
      end
      if (e_arv) begin
        total++;
        if (m_axil_araddr !== e_addr) begin
          bad++; $display("FAIL %s c=%0d araddr got=%h want=%h", name, c, m_axil_araddr, e_addr);
        end
      end
      if (e_ack) begin
        total++;
        if (reg_rd_data !== e_data) begin
          bad++; $display("FAIL %s c=%0d data got=%h want=%h", name, c, reg_rd_data, e_data);
        end
        total++;
        if (reg_rd_err !== e_err) begin
          bad++; $display("FAIL %s c=%0d err got=%b want=%b", name, c, reg_rd_err, e_err);
        end
      end

      // Drive requester and slave for this cycle; unused data buses carry junk.
      reg_rd_en      = 1'b0;
      reg_rd_addr    = $urandom;
      m_axil_arready = 1'b0;
      m_axil_rvalid  = 1'b0;
      m_axil_rdata   = $urandom;
      m_axil_rresp   = 2'($urandom);
      foreach (plan_q[i]) begin
        if (c >= plan_q[i].r && c <= plan_q[i].ack) reg_rd_en = 1'b1;
        if (c == plan_q[i].a) reg_rd_addr = plan_q[i].addr;
        if (c == plan_q[i].a + 1 + plan_q[i].ars) m_axil_arready = 1'b1;
        if (c == plan_q[i].a + 2 + plan_q[i].ars + plan_q[i].rs) begin
          m_axil_rvalid = 1'b1;
          m_axil_rdata  = plan_q[i].data;
          m_axil_rresp  = plan_q[i].resp;
        end
      end
    end
    plan_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({reg_rd_data, reg_rd_wait, reg_rd_ack, reg_rd_err, timeout_evt,
         m_axil_araddr, m_axil_arvalid, m_axil_rready} !== '0) begin
      bad++;
      $display("FAIL %s outputs got data=%h wait=%b ack=%b err=%b tmo=%b araddr=%h arvalid=%b rready=%b want all 0",
               name, reg_rd_data, reg_rd_wait, reg_rd_ack, reg_rd_err, timeout_evt,
               m_axil_araddr, m_axil_arvalid, m_axil_rready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reg_rd_en = 1'b0; reg_rd_addr = '0;
    m_axil_arready = 1'b0; m_axil_rvalid = 1'b0; m_axil_rdata = '0; m_axil_rresp = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_release");
  endtask

  task automatic test_single_read();
    add_req(32'h0000_0010, 0, 0, 2'b00, 32'hA5A5_1234, 0);
    run_plan("single_read");
  endtask

  task automatic test_backpressure();
    // arready 5 cycles late, rvalid 3 cycles after the AR handshake.
    add_req(32'h0000_0ABC, 5, 2, 2'b00, 32'h1357_9BDF, 0);
    run_plan("backpressure");
  endtask

  task automatic test_slverr();
    add_req(32'h0000_0040, 0, 0, 2'b10, 32'h0000_BEEF, 0);
    add_req(32'h0000_0044, 1, 1, 2'b11, 32'hDEAD_0001, 2);
    run_plan("slverr");
  endtask

  task automatic test_timeout();
    // AR held off 20 cycles; the next request is raised right after the timeout ack.
    add_req(32'h0000_0080, 20, 0, 2'b00, 32'h1111_1111, 0);
    add_req(32'h0000_0084, 0, 0, 2'b00, 32'h2222_2222, 0);
    run_plan("timeout");
  endtask

  task automatic test_timeout_edges();
    add_req(32'h0000_0100, TO - 1, 0, 2'b00, 32'hAAAA_0001, 1);  // arready on last count
    add_req(32'h0000_0104, 0, TO - 1, 2'b00, 32'hAAAA_0002, 1);  // rvalid on last count
    add_req(32'h0000_0108, 3, 4, 2'b01, 32'hAAAA_0003, 1);       // split stalls, just in time
    add_req(32'h0000_010C, 3, 5, 2'b00, 32'hAAAA_0004, 1);       // timeout inside DATA
    add_req(32'h0000_0110, 0, TO, 2'b00, 32'hAAAA_0005, 0);      // rvalid one cycle too late
    add_req(32'h0000_0114, 0, 0, 2'b00, 32'hAAAA_0006, 0);
    run_plan("timeout_edges");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      add_req(32'h0000_0200 + 32'(4 * i), 0, 0, 2'b00, $urandom, 0);
    run_plan("back_to_back");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      add_req($urandom, int'($urandom_range(0, 10)), int'($urandom_range(0, 6)),
              2'($urandom), $urandom, int'($urandom_range(0, 2)));
    run_plan("random");
  endtask

  task automatic test_reset_mid_data();
    @(negedge clk);
    reg_rd_en = 1'b1; reg_rd_addr = 32'h0000_0300;
    @(negedge clk);
    m_axil_arready = 1'b1;
    @(negedge clk);
    total++;
    if (m_axil_rready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_data rready got=%b want=1", m_axil_rready);
    end
    m_axil_arready = 1'b0;
    reg_rd_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("rst_mid_data");
    // Late R beat after reset must be ignored.
    m_axil_rvalid = 1'b1; m_axil_rdata = 32'h5555_AAAA; m_axil_rresp = 2'b00;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      m_axil_rvalid = 1'b0;
      total++;
      if (reg_rd_ack !== 1'b0 || reg_rd_wait !== 1'b0 || m_axil_arvalid !== 1'b0 || m_axil_rready !== 1'b0) begin
        bad++;
        $display("FAIL rst_quiet c=%0d ack=%b wait=%b arvalid=%b rready=%b want all 0",
                 c, reg_rd_ack, reg_rd_wait, m_axil_arvalid, m_axil_rready);
      end
    end
    // The block must be back in IDLE and serve a normal read.
    add_req(32'h0000_0304, 0, 1, 2'b00, 32'h0BAD_F00D, 0);
    run_plan("after_reset");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_backpressure();
    test_slverr();
    test_timeout();
    test_timeout_edges();
    test_back_to_back();
    test_random();
    test_reset_mid_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
